// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, SR/Cause bit
// layout and the exception handler entry point used by the pipeline registers.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// M-stage coprocessor-0: SR/Cause/EPC state, mfc0/mtc0/eret service and the
// combinational exception/interrupt request that flushes the pipeline.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2022_1107
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_EXCcode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut
);

    sr_t         sr_q, sr_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic        unused_pc_low;

    assign unused_pc_low = ^M_PC[1:0];

    // Interrupts and exceptions are both masked while EXL is set, which is
    // what turns a held condition into a single Req pulse.
    always_comb begin
        int_req = (|(HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc_req = (M_EXCcode != EXC_INT) & ~sr_q.exl;
        Req     = (int_req | exc_req) & ~reset;
    end

    assign pc_aligned = word_align(M_PC);

    always_comb begin
        sr_d  = sr_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;

        if (Req) begin
            sr_d.exl = 1'b1;
            exc_d    = int_req ? EXC_INT : M_EXCcode;
            bd_d     = M_BD;
            epc_d    = M_BD ? (pc_aligned - 32'd4) : pc_aligned;
        end else begin
            if (WE && (A2 == CP0_SR)) begin
                sr_d.im  = DIn[SR_IM_LSB +: 6];
                sr_d.exl = DIn[SR_EXL_BIT];
                sr_d.ie  = DIn[SR_IE_BIT];
            end
            if (WE && (A2 == CP0_EPC)) begin
                epc_d = word_align(DIn);
            end
            // eret overrides a same-edge mtc0 for EXL only
            if (EXLClr) begin
                sr_d.exl = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            sr_q  <= sr_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_word                        = '0;
        sr_word[SR_IM_LSB +: 6]        = sr_q.im;
        sr_word[SR_EXL_BIT]            = sr_q.exl;
        sr_word[SR_IE_BIT]             = sr_q.ie;

        cause_word                     = '0;
        cause_word[CAUSE_BD_BIT]       = bd_q;
        cause_word[CAUSE_IP_LSB +: 6]  = ip_q;
        cause_word[CAUSE_EXC_LSB +: 5] = exc_q;
    end

    // Reads see the current registers only; a same-cycle mtc0 is not bypassed.
    always_comb begin
        DOut = '0;
        case (A1)
            CP0_SR:    DOut = sr_word;
            CP0_CAUSE: DOut = cause_word;
            CP0_EPC:   DOut = epc_q;
            CP0_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule
